// File: rtl/product_bcd_converter_if.sv
// ============================================================================
// Module      : product_bcd_converter_if
// Description : Request/result bundle between the multiplier side and the
//               binary-to-BCD converter. The master drives start/bin. The
//               slave returns busy/done and the three BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface product_bcd_converter_if;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  hundreds,
    input  tens,
    input  ones
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output hundreds,
    output tens,
    output ones
  );
endinterface

`default_nettype wire

// File: rtl/product_bcd_converter.sv
// ============================================================================
// Module      : product_bcd_converter
// Description : Sequential 8-bit binary to 3-digit BCD converter. It uses
//               double-dabble with one add-3/shift iteration per clock.
//               Optional macro PRODUCT_BCD_BLANK_EN turns leading zeros
//               into the blank code 4'hF when a result is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_bcd_converter (
  input  wire                      clk,
  input  wire                      rst,
  product_bcd_converter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] C_BLANK = 4'hF;

  state_t      state_q, state_d;
  logic [19:0] work_q,  work_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic [3:0]  hund_q,  hund_d;
  logic [3:0]  tens_q,  tens_d;
  logic [3:0]  ones_q,  ones_d;

  logic [19:0] w_adj;
  logic [3:0]  w_h, w_t, w_o;

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Apply the corrections to the three BCD nibbles. The low byte still holds
  // unconverted binary bits, so it passes through unchanged.
  always_comb begin
    w_adj = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8]),
             work_q[7:0]};
  end

  assign w_h = work_q[19:16];
  assign w_t = work_q[15:12];
  assign w_o = work_q[11:8];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = {12'b0, bus.bin};
          cnt_d   = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = w_adj << 1;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef PRODUCT_BCD_BLANK_EN
        hund_d = (w_h == 4'd0) ? C_BLANK : w_h;
        tens_d = ((w_h == 4'd0) && (w_t == 4'd0)) ? C_BLANK : w_t;
`else
        hund_d = w_h;
        tens_d = w_t;
`endif
        ones_d  = w_o;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // busy follows the state that will be entered on this edge, so it is a
    // clean registered flag for the whole SHIFT/DONE window.
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. An asynchronous reset drops any conversion
  // that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= 20'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hundreds = hund_q;
  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;

  // C_BLANK is only referenced in the blanking build.
  logic w_unused;
  assign w_unused = ^C_BLANK;

endmodule

`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
// ============================================================================
// Module      : tb_product_bcd_converter
// Description : Self-checking bench for product_bcd_converter. A timeline
//               model derives the expected busy/done/digits from decimal
//               arithmetic, and directed scenarios pin literal results.
//               Honours PRODUCT_BCD_BLANK_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  product_bcd_converter_if bus();

  product_bcd_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef PRODUCT_BCD_BLANK_EN
  localparam logic [3:0] C_Z = 4'hF;
`else
  localparam logic [3:0] C_Z = 4'h0;
`endif

  int checks = 0;
  int errors = 0;

  // Decimal digits of v, with leading-zero blanking when enabled.
  function automatic logic [11:0] ref_digits(input int v);
    int h, t, o;
    logic [3:0] hh, tt, oo;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
`ifdef PRODUCT_BCD_BLANK_EN
    if (h == 0) begin
      if (t == 0) t = 15;
      h = 15;
    end
`endif
    hh = h[3:0];
    tt = t[3:0];
    oo = o[3:0];
    return {hh, tt, oo};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: phase counts cycles since the accepting edge. A result
  // appears nine edges after acceptance, and the converter is idle again
  // on the following cycle.
  int         m_phase = 0;
  int         m_val   = 0;
  logic [11:0] m_dig  = 12'h000;
  logic       m_done  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_val   <= 0;
      m_dig   <= 12'h000;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_phase == 0) begin
        if (bus.start) begin
          m_phase <= 1;
          m_val   <= int'(bus.bin);
        end
      end else if (m_phase == 9) begin
        m_phase <= 0;
        m_dig   <= ref_digits(m_val);
        m_done  <= 1'b1;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy",   {11'b0, bus.busy}, {11'b0, (m_phase != 0)});
    chk("done",   {11'b0, bus.done}, {11'b0, m_done});
    chk("digits", {bus.hundreds, bus.tens, bus.ones}, m_dig);
  end

  function automatic logic [11:0] dut_dig();
    return {bus.hundreds, bus.tens, bus.ones};
  endfunction

  // Single start pulse. Returns 2 time units after the accepting edge.
  task automatic go(input logic [7:0] v);
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.bin   = v;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  // Number of cycles after the last edge until done is seen, with a bound.
  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_30", name);
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  int lat, cnt;

  initial begin
    bus.start = 1'b0;
    bus.bin   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.busy, bus.done, 10'b0}, 12'h000);
    chk("reset_digits", dut_dig(), 12'h000);
    @(posedge clk); #2;
    rst = 1'b0;

    // Zero input.
    go(8'd0);
    wait_done("zero", lat);
    chk("zero_lat", lat[11:0], 12'd9);
    chk("zero_dig", dut_dig(), {C_Z, C_Z, 4'h0});

    // Maximum product.
    go(8'd225);
    wait_done("max", lat);
    chk("max_lat", lat[11:0], 12'd9);
    chk("max_dig", dut_dig(), 12'h225);

    // Back-to-back with start held high. bin changes after acceptance.
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.bin   = 8'd99;
    @(posedge clk); #2;
    bus.bin   = 8'd100;
    wait_done("b2b_first", lat);
    chk("b2b_first_lat", lat[11:0], 12'd9);
    chk("b2b_first_dig", dut_dig(), {C_Z, 4'h9, 4'h9});
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done("b2b_second", lat);
    chk("b2b_second_lat", lat[11:0], 12'd9);
    chk("b2b_second_dig", dut_dig(), 12'h100);

    // Start during a conversion is ignored.
    go(8'd42);
    repeat (3) @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.bin   = 8'd7;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done("ignore", lat);
    chk("ignore_dig", dut_dig(), {C_Z, 4'h4, 4'h2});
    count_done(15, cnt);
    chk("ignore_extra_done", cnt[11:0], 12'd0);

    // Asynchronous reset in mid-conversion.
    go(8'd255);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_flags", {bus.busy, bus.done, 10'b0}, 12'h000);
    chk("midrst_dig", dut_dig(), 12'h000);
    @(posedge clk); #2;
    rst = 1'b0;
    count_done(15, cnt);
    chk("midrst_no_done", cnt[11:0], 12'd0);
    go(8'd36);
    wait_done("after_rst", lat);
    chk("after_rst_dig", dut_dig(), {C_Z, 4'h3, 4'h6});

    // Every multiplier product a*b.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int p;
        logic [7:0] pb;
        p  = a * b;
        pb = p[7:0];
        go(pb);
        wait_done("mult", lat);
        chk("mult_dig", dut_dig(), ref_digits(p));
      end
    end

    // Full 8-bit range.
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vb;
      vb = v[7:0];
      go(vb);
      wait_done("sweep", lat);
      chk("sweep_dig", dut_dig(), ref_digits(v));
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
